// File: rtl/dma_arbiter_pkg.sv
// dma_arbiter_pkg: shared widths, state/pick types and the round-robin pick for the DMA arbiter
package dma_arbiter_pkg;
    localparam int DMA_AW = 22;
    localparam int DMA_NREQ_MAX = 4;
    localparam int OWN_W = 2;

    typedef logic [OWN_W-1:0] own_t;
    typedef enum logic {IDLE, OWNED} arb_state_t;
    typedef struct packed {
        logic hit;
        own_t idx;
    } pick_t;

    // First set request at or after ptr, wrapping at n; descending scan lets the nearest one win.
    function automatic pick_t rr_pick(input logic [DMA_NREQ_MAX-1:0] req, input own_t ptr, input int n);
        pick_t p;
        int j;
        p = '0;
        for (int k = DMA_NREQ_MAX - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = j >= n ? j - n : j;
            if (k < n && req[j[OWN_W-1:0]]) p = '{hit: 1'b1, idx: j[OWN_W-1:0]};
        end
        return p;
    endfunction
endpackage

// File: rtl/dma_arbiter_if.sv
// dma_arbiter_if: the single memory-DMA access port between the arbiter and dma_access
interface dma_arbiter_if import dma_arbiter_pkg::*; #(parameter int AW = DMA_AW);
    logic          dma_req;
    logic          dma_rnw;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wd;
    logic          dma_ack;
    logic          dma_end;
    logic [7:0]    dma_rd;

    modport master (output dma_req, dma_rnw, dma_addr, dma_wd, input dma_ack, dma_end, dma_rd);
    modport slave (input dma_req, dma_rnw, dma_addr, dma_wd, output dma_ack, dma_end, dma_rd);
endinterface

// File: rtl/dma_arb_idfifo.sv
// dma_arb_idfifo: 2-deep queue of owner indices for accepted accesses still awaiting dma_end
module dma_arb_idfifo import dma_arbiter_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  own_t din,
    output logic full,
    output logic empty,
    output own_t head
);
    own_t mem [2];
    logic wp, rp, do_push, do_pop;
    logic [1:0] cnt;

    assign full = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign head = mem[rp];
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem <= '{default: '0};
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) mem[wp] <= din;
            wp <= wp ^ do_push;
            rp <= rp ^ do_pop;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
endmodule

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin grant of the dma_access port with burst lock; routes
// each dma_end back to the requester whose access it completes.
module dma_arbiter import dma_arbiter_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int AW = DMA_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]    r_req,
    input  logic [N_REQ-1:0]    r_rnw,
    input  logic [N_REQ-1:0]    r_lock,
    input  logic [N_REQ*AW-1:0] r_addr,
    input  logic [N_REQ*8-1:0]  r_wd,
    output logic [N_REQ-1:0]    r_ack,
    output logic [N_REQ-1:0]    r_end,
    output logic [7:0]          r_rd,
    dma_arbiter_if.master       bus,
    output logic [N_REQ-1:0]    grant,
    output logic                proto_err
);
    localparam int NM = DMA_NREQ_MAX;

    arb_state_t state, state_nx;
    own_t owner, owner_nx, rr_ptr, rr_ptr_nx, head;
    pick_t pk;
    logic [NM-1:0] req_x, rnw_x, lock_x;
    logic [NM*AW-1:0] addr_x;
    logic [NM*8-1:0] wd_x;
    logic owned, acc, done, full, empty;

    // Requester vectors padded to the maximum so the 2-bit owner index is always in range.
    assign req_x = NM'(r_req);
    assign rnw_x = NM'(r_rnw);
    assign lock_x = NM'(r_lock);
    assign addr_x = (NM*AW)'(r_addr);
    assign wd_x = (NM*8)'(r_wd);

    assign owned = state == OWNED;
    assign acc = owned & bus.dma_ack;
    assign done = bus.dma_end & ~empty;
    assign pk = rr_pick(req_x, rr_ptr, N_REQ);

    assign grant = owned ? N_REQ'(1) << owner : '0;
    assign r_ack = acc ? grant : '0;
    assign r_end = done ? N_REQ'(1) << head : '0;
    assign r_rd = bus.dma_rd;
    assign bus.dma_req = owned & req_x[owner] & ~full;
    assign bus.dma_rnw = owned & rnw_x[owner];
    assign bus.dma_addr = owned ? addr_x[int'(owner)*AW +: AW] : '0;
    assign bus.dma_wd = owned ? wd_x[int'(owner)*8 +: 8] : '0;

    // An unlocked ack or a withdrawn request drops to IDLE; the next pick starts after the old owner.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_ptr_nx = rr_ptr;
        if (!owned && pk.hit) begin
            state_nx = OWNED;
            owner_nx = pk.idx;
            rr_ptr_nx = pk.idx == own_t'(N_REQ - 1) ? '0 : pk.idx + 1'b1;
        end else if (owned && (acc ? !lock_x[owner] : !req_x[owner])) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            rr_ptr <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            rr_ptr <= rr_ptr_nx;
            proto_err <= proto_err | (bus.dma_end & empty);
        end

    dma_arb_idfifo u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (acc),
        .pop  (bus.dma_end),
        .din  (owner),
        .full (full),
        .empty(empty),
        .head (head)
    );
endmodule
